// File: rtl/fir_pkg.sv
// Shared FIR pipeline constants and the tap sequencer state encoding.
// The FIFO, sequencer and MAC all size their buses from here.
package fir_pkg;

    localparam int DATA_W = 16;
    localparam int TAPS   = 64;
    localparam int TAP_W  = 6;
    localparam int FILL_W = TAP_W + 1;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/fir_sample_ram.sv
// Circular delay-line storage: synchronous write, asynchronous read, no reset.
// Stale contents after reset are masked by the sequencer's fill counter.
module fir_sample_ram
    import fir_pkg::*;
(
    input  logic              clk2,
    input  logic              we,
    input  logic [TAP_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [TAP_W-1:0]  rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [TAPS];

    always_ff @(posedge clk2) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fir_tap_sequencer.sv
// Writes each accepted sample into the delay line and streams one burst of
// TAPS (sample, tap) pairs, newest first, back-to-back with no bubbles.
module fir_tap_sequencer
    import fir_pkg::*;
(
    input  logic              clk2,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mac_valid,
    output logic [DATA_W-1:0] mac_sample,
    output logic [TAP_W-1:0]  mac_tap,
    output logic              mac_first,
    output logic              mac_last,
    output logic              overrun,
    output logic              busy
);

    state_t             state, state_nxt;
    logic [TAP_W-1:0]   cnt, cnt_nxt;
    logic [TAP_W-1:0]   wr_idx, wr_idx_nxt;
    logic [TAP_W-1:0]   base, base_nxt;
    logic [FILL_W-1:0]  fill, fill_nxt;

    logic               valid_nxt;
    logic [DATA_W-1:0]  sample_nxt;
    logic [TAP_W-1:0]   tap_nxt;
    logic               first_nxt;
    logic               last_nxt;
    logic               overrun_nxt;

    logic               accept;
    logic               last_tap;
    logic [TAP_W-1:0]   next_tap;
    logic [TAP_W-1:0]   rd_addr;
    logic [DATA_W-1:0]  rd_data;

    assign last_tap = (cnt == TAP_W'(TAPS - 1));
    assign in_ready = (state == ST_IDLE) || ((state == ST_RUN) && last_tap);
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_RUN);
    assign next_tap = cnt + 1'b1;
    // Output registers run one tap ahead of cnt, so the RAM is read for tap cnt+1.
    assign rd_addr  = base - next_tap;

    fir_sample_ram u_ram (
        .clk2    (clk2),
        .we      (accept),
        .wr_addr (wr_idx),
        .wr_data (in_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    always_ff @(posedge clk2 or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            wr_idx     <= '0;
            base       <= '0;
            fill       <= '0;
            mac_valid  <= 1'b0;
            mac_sample <= '0;
            mac_tap    <= '0;
            mac_first  <= 1'b0;
            mac_last   <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            wr_idx     <= wr_idx_nxt;
            base       <= base_nxt;
            fill       <= fill_nxt;
            mac_valid  <= valid_nxt;
            mac_sample <= sample_nxt;
            mac_tap    <= tap_nxt;
            mac_first  <= first_nxt;
            mac_last   <= last_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        wr_idx_nxt  = wr_idx;
        base_nxt    = base;
        fill_nxt    = fill;
        valid_nxt   = 1'b0;
        sample_nxt  = '0;
        tap_nxt     = '0;
        first_nxt   = 1'b0;
        last_nxt    = 1'b0;
        overrun_nxt = overrun || (in_valid && !in_ready);

        if (accept) begin
            // Tap 0 is bypassed straight from in_data; the RAM write lands this edge.
            state_nxt  = ST_RUN;
            cnt_nxt    = '0;
            base_nxt   = wr_idx;
            wr_idx_nxt = wr_idx + 1'b1;
            fill_nxt   = (fill == FILL_W'(TAPS)) ? fill : fill + 1'b1;
            valid_nxt  = 1'b1;
            sample_nxt = in_data;
            first_nxt  = 1'b1;
        end else if (state == ST_RUN) begin
            if (last_tap) begin
                state_nxt = ST_IDLE;
                cnt_nxt   = '0;
            end else begin
                cnt_nxt    = next_tap;
                valid_nxt  = 1'b1;
                tap_nxt    = next_tap;
                sample_nxt = ({1'b0, next_tap} < fill) ? rd_data : '0;
                last_nxt   = (next_tap == TAP_W'(TAPS - 1));
            end
        end
    end

endmodule

// File: tb/tb_fir_tap_sequencer.sv
// Directed + random bench for fir_tap_sequencer against a sample-history model.
module tb_fir_tap_sequencer;
    import fir_pkg::*;

    logic              clk2 = 1'b0;
    logic              rst = 1'b0;
    logic              in_valid = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready;
    logic              mac_valid;
    logic [DATA_W-1:0] mac_sample;
    logic [TAP_W-1:0]  mac_tap;
    logic              mac_first;
    logic              mac_last;
    logic              overrun;
    logic              busy;

    int vectors = 0;
    int miscompares = 0;

    int                pos = -1;
    logic [DATA_W-1:0] burst [TAPS];
    logic [DATA_W-1:0] hist [$];
    logic              exp_ovr = 1'b0;

    always #5 clk2 = ~clk2;

    fir_tap_sequencer dut (
        .clk2       (clk2),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mac_valid  (mac_valid),
        .mac_sample (mac_sample),
        .mac_tap    (mac_tap),
        .mac_first  (mac_first),
        .mac_last   (mac_last),
        .overrun    (overrun),
        .busy       (busy)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_mac();
        check_output("mac_valid", 32'(mac_valid), 32'(pos >= 0));
        check_output("busy", 32'(busy), 32'(pos >= 0));
        check_output("overrun", 32'(overrun), 32'(exp_ovr));
        if (pos >= 0) begin
            check_output("mac_tap", 32'(mac_tap), 32'(pos));
            check_output("mac_sample", 32'(mac_sample), 32'(burst[pos]));
            check_output("mac_first", 32'(mac_first), 32'(pos == 0));
            check_output("mac_last", 32'(mac_last), 32'(pos == TAPS - 1));
        end else begin
            check_output("mac_first", 32'(mac_first), 32'd0);
            check_output("mac_last", 32'(mac_last), 32'd0);
        end
    endtask

    task automatic check_reset_values();
        check_output("rst_mac_valid", 32'(mac_valid), 32'd0);
        check_output("rst_mac_sample", 32'(mac_sample), 32'd0);
        check_output("rst_mac_tap", 32'(mac_tap), 32'd0);
        check_output("rst_mac_first", 32'(mac_first), 32'd0);
        check_output("rst_mac_last", 32'(mac_last), 32'd0);
        check_output("rst_busy", 32'(busy), 32'd0);
        check_output("rst_overrun", 32'(overrun), 32'd0);
        check_output("rst_in_ready", 32'(in_ready), 32'd1);
    endtask

    // One clock: drive inputs, check in_ready, advance model, check outputs.
    task automatic apply_stimulus(input logic v, input logic [DATA_W-1:0] d);
        logic rdy;
        in_valid = v;
        in_data  = d;
        rdy = (pos < 0) || (pos == TAPS - 1);
        check_output("in_ready", 32'(in_ready), 32'(rdy));
        @(posedge clk2);
        #1;
        in_valid = 1'b0;
        if (v && rdy) begin
            hist.push_back(d);
            if (hist.size() > TAPS) void'(hist.pop_front());
            for (int k = 0; k < TAPS; k++)
                burst[k] = (k < hist.size()) ? hist[hist.size() - 1 - k] : '0;
            pos = 0;
        end else if (pos >= 0) begin
            pos = (pos == TAPS - 1) ? -1 : pos + 1;
        end
        if (v && !rdy) exp_ovr = 1'b1;
        check_mac();
    endtask

    task automatic feed(input logic [DATA_W-1:0] d);
        int guard = 0;
        while (!((pos < 0) || (pos == TAPS - 1)) && guard < 4 * TAPS) begin
            apply_stimulus(1'b0, '0);
            guard++;
        end
        check_output("feed_timeout", 32'(guard < 4 * TAPS), 32'd1);
        apply_stimulus(1'b1, d);
    endtask

    task automatic run_until(input int target);
        int guard = 0;
        while (pos != target && guard < 4 * TAPS) begin
            apply_stimulus(1'b0, '0);
            guard++;
        end
        check_output("run_timeout", 32'(pos == target), 32'd1);
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        #1;
        pos = -1;
        hist.delete();
        exp_ovr = 1'b0;
        check_reset_values();
        repeat (cycles) @(posedge clk2);
        #1;
        rst = 1'b0;
        #1;
        check_reset_values();
    endtask

    initial begin
        logic v;
        $display("[TB] start");
        #2;
        do_reset(3);

        $display("[TB] first sample");
        feed(16'h0100);
        run_until(-1);

        $display("[TB] back-to-back");
        feed(16'h0001);
        feed(16'h0002);
        feed(16'h0003);
        run_until(-1);

        $display("[TB] wrap");
        do_reset(2);
        for (int i = 1; i <= 70; i++) feed(DATA_W'(i));
        run_until(-1);

        $display("[TB] overrun");
        feed(16'h1234);
        run_until(10);
        apply_stimulus(1'b1, 16'hBEEF);
        feed(16'h4321);
        run_until(-1);

        $display("[TB] reset mid-burst");
        feed(16'h5555);
        run_until(30);
        do_reset(3);
        feed(16'h7FFF);
        run_until(-1);

        $display("[TB] random");
        for (int i = 0; i < 1500; i++) begin
            v = ($urandom_range(0, 7) == 0) || ((pos == TAPS - 1) && ($urandom_range(0, 3) != 0));
            apply_stimulus(v, DATA_W'($urandom));
        end
        run_until(-1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
